rf68000_ring_server: RTL
========================

RF68000_RING_SERVER -- requirements
Module: rf68000_ring_server

Interface
REQ-001 SHALL have parameter ID, default 6'd62: ring node id this server answers.
REQ-002 SHALL have parameter DEPTH, default 4: request FIFO entries (power of 2).
REQ-003 SHALL have parameter TMO, default 8'd255: bus timeout in cycles.
REQ-004 SHALL have port clk_i  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port rst_ni  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports packet_i input / packet_o output, nic_pkg packet_t: request ring in/out.
REQ-007 SHALL have ports rpacket_i input / rpacket_o output, nic_pkg packet_t: response ring in/out.
REQ-008 SHALL have ports m_cyc_o, m_stb_o, m_we_o  output  1  Wishbone master controls.
REQ-009 SHALL have ports m_sel_o output 4; m_adr_o, m_dat_o output 32; m_dat_i input 32.
REQ-010 SHALL have ports m_ack_i, m_err_i  input  1  bus termination.
REQ-011 SHALL have ports full_o, busy_o  output  1  FIFO full; FSM not IDLE.

Function
REQ-012 SHALL register both rings every cycle: packet_o <= packet_i and rpacket_o <= rpacket_i unless overridden below.
REQ-013 SHALL capture a packet when packet_i.did==ID, typ is PT_READ, PT_AREAD or PT_WRITE, and FIFO not full: enqueue it and drive packet_o to all-zero.
REQ-014 When FIFO is full, a matching packet SHALL pass through unchanged and be retried on its next lap.
REQ-015 SHALL pass through untouched: broadcasts (did==63), other types, and packets for other ids.
REQ-016 SHALL never originate packets on the request ring.
REQ-017 FIFO SHALL support simultaneous enqueue and dequeue in one cycle; count stays unchanged, no data loss, including when full.
REQ-018 FSM states: IDLE, BUS, RESP.
REQ-019 IDLE: if FIFO not empty, SHALL assert m_cyc_o=m_stb_o=1 and load head entry. Loaded fields: m_we_o=we, m_adr_o=adr, m_dat_o=dat; m_sel_o=sel for write, 4'hF for read. SHALL clear the timeout counter and go to BUS.
REQ-020 BUS: timeout counter SHALL increment each cycle that neither m_ack_i nor m_err_i is high.
REQ-021 BUS, m_ack_i=1: SHALL deassert cyc/stb/we and set sel to 0. Write: pop FIFO, go to IDLE. Read: latch m_dat_i into the response, go to RESP.
REQ-022 BUS, m_err_i=1 or counter==TMO (ack takes precedence): SHALL end the cycle as in REQ-021. Write: pop, IDLE. Read: response typ=PT_ERR, dat=0, go to RESP.
REQ-023 Response packet fields: sid=ID, did=request sid, age=0, ack=1, adr=request adr. typ=PT_AACK for PT_AREAD, PT_ACK for PT_READ, PT_ERR per REQ-022. All other fields 0.
REQ-024 RESP: on the first edge where (rpacket_i.sid|rpacket_i.did)==0, SHALL drive rpacket_o <= response, pop FIFO, go to IDLE. Otherwise hold the response and keep passing the ring through.
REQ-025 Minimum latency: request captured at edge E -> m_cyc_o high after E+1. Ack at edge A with empty slot at A+1 -> response on rpacket_o after A+1.
REQ-026 Head entry SHALL stay in the FIFO until its transaction completes (pop only on REQ-021/022/024).
REQ-027 Only one bus transaction SHALL be outstanding at a time; FIFO order preserved.
REQ-028 full_o SHALL equal count==DEPTH; busy_o SHALL equal state!=IDLE.

Reset
REQ-029 With rst_ni low at an edge, SHALL set packet_o, rpacket_o and response register to all-zero. SHALL set m_cyc_o, m_stb_o, m_we_o=0, m_sel_o=0, m_adr_o=0, m_dat_o=0. SHALL empty the FIFO and set state IDLE.
REQ-030 Reset mid-transaction SHALL drop the cycle immediately (cyc low next cycle) and discard all queued requests and any pending response.

Verification
REQ-031 Read: packet did=62, sid=5, PT_READ, adr=0x40001000; ack with m_dat_i=0x12345678, empty slot -> rpacket_o sid=62, did=5, PT_ACK, dat=0x12345678.
REQ-032 Write: did=62, PT_WRITE, sel=4'h3, dat=0xCAFE -> one write cycle with sel=3 and dat=0xCAFE; no response packet; packet_o zeroed on capture.
REQ-033 Full: 5 back-to-back requests with m_ack_i held low -> 4 captured, full_o=1, 5th passes through unchanged. Timeout after 256 BUS cycles -> PT_ERR response for read.
REQ-034 Response blocking: response ready while rpacket_i occupied for 10 cycles -> response held, ring passes through, response inserted on first empty slot.
REQ-035 Filtering: did=63 PT_WRITE and did=7 PT_READ -> both passed unchanged, no bus cycle.
REQ-036 Reset during BUS with 2 queued -> cyc drops, FIFO empty, no response emitted afterward.

Source files
------------

// File: rtl/rf68000_ring_server.sv
// Ring bus server: captures read/write requests addressed to this node, performs them as
// Wishbone master cycles in arrival order and returns read results on the response ring.
package nic_pkg;
  typedef enum logic [3:0] {
    PT_NULL  = 4'd0,
    PT_READ  = 4'd1,
    PT_WRITE = 4'd2,
    PT_AREAD = 4'd3,
    PT_ACK   = 4'd4,
    PT_AACK  = 4'd5,
    PT_ERR   = 4'd6
  } pkt_type_t;

  typedef struct packed {
    logic [5:0]  did;
    logic [5:0]  sid;
    logic [5:0]  age;
    logic        ack;
    pkt_type_t   typ;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } packet_t;
endpackage

module rf68000_ring_server
  import nic_pkg::*;
#(
  parameter logic [5:0] ID    = 6'd62,
  parameter int          DEPTH = 4,
  parameter logic [7:0]  TMO   = 8'd255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  packet_t     packet_i,
  output packet_t     packet_o,
  input  packet_t     rpacket_i,
  output packet_t     rpacket_o,
  output logic        m_cyc_o,
  output logic        m_stb_o,
  output logic        m_we_o,
  output logic [3:0]  m_sel_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  input  logic        m_ack_i,
  input  logic        m_err_i,
  output logic        full_o,
  output logic        busy_o
);
  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [5:0]  sid;
    pkt_type_t   typ;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
  } req_t;

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  req_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  state_t        state;
  logic [7:0]    tmo_cnt;
  packet_t       resp, nxt_resp;
  req_t          head;
  logic          is_req, capture, pop, bus_done, slot_free;

  assign head      = mem[rd_ptr];
  assign is_req    = (packet_i.did == ID) && (packet_i.did != 6'h3F) &&
                     (packet_i.typ inside {PT_READ, PT_AREAD, PT_WRITE});
  assign full_o    = (count == (AW+1)'(DEPTH));
  assign busy_o    = (state != IDLE);
  assign bus_done  = (state == BUS) && (m_ack_i || m_err_i || tmo_cnt == TMO);
  assign slot_free = ((rpacket_i.sid | rpacket_i.did) == '0);
  // The head entry leaves only when its transaction is fully finished; a pop in the same
  // cycle frees a slot, so a full FIFO can still accept a request then.
  assign pop       = (bus_done && head.typ == PT_WRITE) || (state == RESP && slot_free);
  assign capture   = is_req && (!full_o || pop);

  always_comb begin
    nxt_resp     = '0;
    nxt_resp.sid = ID;
    nxt_resp.did = head.sid;
    nxt_resp.ack = 1'b1;
    nxt_resp.adr = head.adr;
    if (m_ack_i) begin
      nxt_resp.typ = (head.typ == PT_AREAD) ? PT_AACK : PT_ACK;
      nxt_resp.dat = m_dat_i;
    end else begin
      nxt_resp.typ = PT_ERR;
    end
  end

  always_ff @(posedge clk_i) begin
    if (capture)
      mem[wr_ptr] <= '{sid: packet_i.sid, typ: packet_i.typ, we: packet_i.we,
                       sel: packet_i.sel, adr: packet_i.adr, dat: packet_i.dat};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({capture, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      packet_o  <= '0;
      rpacket_o <= '0;
      resp      <= '0;
      state     <= IDLE;
      tmo_cnt   <= '0;
      m_cyc_o   <= 1'b0;
      m_stb_o   <= 1'b0;
      m_we_o    <= 1'b0;
      m_sel_o   <= '0;
      m_adr_o   <= '0;
      m_dat_o   <= '0;
    end else begin
      packet_o  <= capture ? '0 : packet_i;
      rpacket_o <= rpacket_i;
      case (state)
        IDLE: begin
          if (count != '0) begin
            m_cyc_o <= 1'b1;
            m_stb_o <= 1'b1;
            m_we_o  <= head.we;
            m_adr_o <= head.adr;
            m_dat_o <= head.dat;
            m_sel_o <= (head.typ == PT_WRITE) ? head.sel : 4'hF;
            tmo_cnt <= '0;
            state   <= BUS;
          end
        end
        BUS: begin
          if (bus_done) begin
            m_cyc_o <= 1'b0;
            m_stb_o <= 1'b0;
            m_we_o  <= 1'b0;
            m_sel_o <= '0;
            if (head.typ == PT_WRITE) begin
              state <= IDLE;
            end else begin
              resp  <= nxt_resp;
              state <= RESP;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          // Insert only into an empty slot; otherwise keep forwarding ring traffic.
          if (slot_free) begin
            rpacket_o <= resp;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
